// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two requesters, the register-file write port and decode's hazard check.
interface rf_wb_arbiter_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3
);
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [ADDR_W-1:0] chk_addr1;
   logic [ADDR_W-1:0] chk_addr2;
   logic              hazard1;
   logic              hazard2;
   logic              grant_mem;

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      output alu_ready,
      input  mem_valid, mem_addr, mem_data,
      output mem_ready,
      output rf_we, rf_waddr, rf_wdata,
      input  chk_addr1, chk_addr2,
      output hazard1, hazard2, grant_mem
   );

   modport master (
      output alu_valid, alu_addr, alu_data,
      input  alu_ready,
      output mem_valid, mem_addr, mem_data,
      input  mem_ready,
      input  rf_we, rf_waddr, rf_wdata,
      output chk_addr1, chk_addr2,
      input  hazard1, hazard2, grant_mem
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester arbiter for the register file's single write port: one-entry buffers,
// round-robin (or memory-first) grant, same-register age ordering and pending-write hazards.
module rf_wb_arbiter #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 3,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input logic             clk,
   input logic             reset,
   rf_wb_arbiter_if.slave  wb
);
   logic              alu_full_q, alu_full_d;
   logic [ADDR_W-1:0] alu_addr_q, alu_addr_d;
   logic [DATA_W-1:0] alu_data_q, alu_data_d;
   logic              mem_full_q, mem_full_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              mem_older_q, mem_older_d;   // when both full: 1 = memory entry is older
   logic              last_grant_q, last_grant_d; // 0 = ALU, 1 = MEM

   logic pick_mem_c;
   logic grant_alu_c;
   logic grant_mem_c;
   logic alu_ready_c;
   logic mem_ready_c;
   logic alu_load_c;
   logic mem_load_c;
   logic write_c;

   // Grant depends only on buffered state so the write port is stable all cycle.
   always_comb begin
      pick_mem_c = mem_full_q;
      if (alu_full_q && mem_full_q) begin
         if (alu_addr_q == mem_addr_q) pick_mem_c = mem_older_q;
         else                          pick_mem_c = FIXED_PRIO ? 1'b1 : ~last_grant_q;
      end
   end

   assign grant_mem_c = mem_full_q & pick_mem_c;
   assign grant_alu_c = alu_full_q & ~pick_mem_c;
   assign write_c     = alu_full_q | mem_full_q;
   assign alu_ready_c = ~alu_full_q | grant_alu_c;
   assign mem_ready_c = ~mem_full_q | grant_mem_c;
   assign alu_load_c  = wb.alu_valid & alu_ready_c;
   assign mem_load_c  = wb.mem_valid & mem_ready_c;

   assign wb.alu_ready = alu_ready_c;
   assign wb.mem_ready = mem_ready_c;
   assign wb.grant_mem = grant_mem_c;
   assign wb.rf_we     = write_c;
   assign wb.rf_waddr  = grant_mem_c ? mem_addr_q : (grant_alu_c ? alu_addr_q : '0);
   assign wb.rf_wdata  = grant_mem_c ? mem_data_q : (grant_alu_c ? alu_data_q : '0);
   assign wb.hazard1   = (alu_full_q && (alu_addr_q == wb.chk_addr1)) ||
                         (mem_full_q && (mem_addr_q == wb.chk_addr1));
   assign wb.hazard2   = (alu_full_q && (alu_addr_q == wb.chk_addr2)) ||
                         (mem_full_q && (mem_addr_q == wb.chk_addr2));

   // Commit/refill of each buffer; a same-edge pair puts the load ahead of the ALU result.
   always_comb begin
      alu_full_d   = alu_full_q;
      alu_addr_d   = alu_addr_q;
      alu_data_d   = alu_data_q;
      mem_full_d   = mem_full_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      mem_older_d  = mem_older_q;
      last_grant_d = last_grant_q;

      if (grant_alu_c) alu_full_d = 1'b0;
      if (grant_mem_c) mem_full_d = 1'b0;
      if (write_c)     last_grant_d = grant_mem_c;

      if (mem_load_c) begin
         mem_full_d  = 1'b1;
         mem_addr_d  = wb.mem_addr;
         mem_data_d  = wb.mem_data;
         mem_older_d = 1'b0;
      end
      if (alu_load_c) begin
         alu_full_d  = 1'b1;
         alu_addr_d  = wb.alu_addr;
         alu_data_d  = wb.alu_data;
         mem_older_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_full_q   <= 1'b0;
         alu_addr_q   <= '0;
         alu_data_q   <= '0;
         mem_full_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_older_q  <= 1'b0;
         last_grant_q <= 1'b0;
      end else begin
         alu_full_q   <= alu_full_d;
         alu_addr_q   <= alu_addr_d;
         alu_data_q   <= alu_data_d;
         mem_full_q   <= mem_full_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_older_q  <= mem_older_d;
         last_grant_q <= last_grant_d;
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector tables for both priority modes plus a
// randomized phase against a sequence-number reference model of the round-robin arbiter.
module tb_rf_wb_arbiter;
   logic clk;
   logic rst;
   logic rst_f;
   logic cap_en;
   int   total;
   int   bad;

   rf_wb_arbiter_if mif ();
   rf_wb_arbiter_if fif ();

   rf_wb_arbiter #(.DATA_W(8), .ADDR_W(3), .FIXED_PRIO(1'b0)) u_dut (
      .clk(clk), .reset(rst), .wb(mif.slave));
   rf_wb_arbiter #(.DATA_W(8), .ADDR_W(3), .FIXED_PRIO(1'b1)) u_fix (
      .clk(clk), .reset(rst_f), .wb(fif.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        av;
      logic [2:0]  aa;
      logic [7:0]  ad;
      logic        mv;
      logic [2:0]  ma;
      logic [7:0]  md;
      logic [2:0]  c1;
      logic [2:0]  c2;
      logic [16:0] want;
   } vec_t;

   typedef struct {
      bit          v;
      logic [2:0]  a;
      logic [7:0]  d;
      int unsigned seq;
   } ent_t;

   vec_t tbl[31];
   vec_t ftbl[11];

   // Register files as seen through each write port.
   logic [7:0] rf_dut[8];
   logic [7:0] rf_fix[8];

   // Reference model: entries carry a program-order sequence number.
   ent_t        m_alu = '{v: 1'b0, a: 3'd0, d: 8'd0, seq: 0};
   ent_t        m_mem = '{v: 1'b0, a: 3'd0, d: 8'd0, seq: 0};
   bit          m_last_mem = 1'b0;
   int unsigned m_seq = 0;
   logic [7:0]  m_rf[8];

   function automatic vec_t mk(input bit r, input bit av, input int aa, input int ad,
                               input bit mv, input int ma, input int md,
                               input int c1, input int c2,
                               input bit we, input int wa, input int wd, input bit gm,
                               input bit ar, input bit mr, input bit h1, input bit h2);
      vec_t v;
      v.rst  = r;
      v.av   = av;
      v.aa   = 3'(aa);
      v.ad   = 8'(ad);
      v.mv   = mv;
      v.ma   = 3'(ma);
      v.md   = 8'(md);
      v.c1   = 3'(c1);
      v.c2   = 3'(c2);
      v.want = {we, 3'(wa), 8'(wd), gm, ar, mr, h1, h2};
      return v;
   endfunction

   function automatic logic [16:0] outs_m();
      return {mif.rf_we, mif.rf_waddr, mif.rf_wdata, mif.grant_mem,
              mif.alu_ready, mif.mem_ready, mif.hazard1, mif.hazard2};
   endfunction

   function automatic logic [16:0] outs_f();
      return {fif.rf_we, fif.rf_waddr, fif.rf_wdata, fif.grant_mem,
              fif.alu_ready, fif.mem_ready, fif.hazard1, fif.hazard2};
   endfunction

   function automatic bit m_pick_mem();
      if (m_alu.v && m_mem.v) begin
         if (m_alu.a == m_mem.a) return m_mem.seq < m_alu.seq;
         return !m_last_mem;
      end
      return m_mem.v;
   endfunction

   function automatic bit m_haz(input logic [2:0] c);
      return (m_alu.v && m_alu.a == c) || (m_mem.v && m_mem.a == c);
   endfunction

   function automatic logic [16:0] m_expect();
      bit gm, ga, we;
      logic [2:0] wa;
      logic [7:0] wd;
      gm = m_pick_mem();
      ga = m_alu.v && !gm;
      we = m_alu.v || m_mem.v;
      wa = gm ? m_mem.a : (ga ? m_alu.a : 3'd0);
      wd = gm ? m_mem.d : (ga ? m_alu.d : 8'd0);
      return {we, wa, wd, gm, !m_alu.v || ga, !m_mem.v || gm,
              m_haz(mif.chk_addr1), m_haz(mif.chk_addr2)};
   endfunction

   // Model update at every edge of the round-robin instance.
   always @(posedge clk) begin
      bit gm, ga, ra, rm;
      gm = m_pick_mem();
      ga = m_alu.v && !gm;
      ra = !m_alu.v || ga;
      rm = !m_mem.v || gm;
      if (m_alu.v || m_mem.v) begin
         if (gm) m_rf[m_mem.a] = m_mem.d;
         else    m_rf[m_alu.a] = m_alu.d;
         m_last_mem = gm;
      end
      if (ga) m_alu.v = 1'b0;
      if (gm) m_mem.v = 1'b0;
      if (rst) begin
         m_alu.v    = 1'b0;
         m_mem.v    = 1'b0;
         m_last_mem = 1'b0;
      end else begin
         if (mif.mem_valid && rm) begin
            m_mem = '{v: 1'b1, a: mif.mem_addr, d: mif.mem_data, seq: m_seq};
            m_seq++;
         end
         if (mif.alu_valid && ra) begin
            m_alu = '{v: 1'b1, a: mif.alu_addr, d: mif.alu_data, seq: m_seq};
            m_seq++;
         end
      end
   end

   // The register file latches during the granted cycle; capture mid-cycle.
   always @(negedge clk) begin
      if (cap_en) begin
         if (mif.rf_we) rf_dut[mif.rf_waddr] = mif.rf_wdata;
         if (fif.rf_we) rf_fix[fif.rf_waddr] = fif.rf_wdata;
      end
   end

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, want);
      end
   endtask

   task automatic run_row(input bit sel, input vec_t v, input string nm);
      if (sel) begin
         rst_f         = v.rst;
         fif.alu_valid = v.av; fif.alu_addr = v.aa; fif.alu_data = v.ad;
         fif.mem_valid = v.mv; fif.mem_addr = v.ma; fif.mem_data = v.md;
         fif.chk_addr1 = v.c1; fif.chk_addr2 = v.c2;
      end else begin
         rst           = v.rst;
         mif.alu_valid = v.av; mif.alu_addr = v.aa; mif.alu_data = v.ad;
         mif.mem_valid = v.mv; mif.mem_addr = v.ma; mif.mem_data = v.md;
         mif.chk_addr1 = v.c1; mif.chk_addr2 = v.c2;
      end
      @(negedge clk);
      check(nm, sel ? outs_f() : outs_m(), v.want);
      @(posedge clk);
      #1;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      cap_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rf_dut[i] = 8'd0;
         rf_fix[i] = 8'd0;
         m_rf[i]   = 8'd0;
      end
      rst = 1'b1;
      rst_f = 1'b1;
      mif.alu_valid = 1'b0; mif.alu_addr = 3'd0; mif.alu_data = 8'd0;
      mif.mem_valid = 1'b0; mif.mem_addr = 3'd0; mif.mem_data = 8'd0;
      mif.chk_addr1 = 3'd0; mif.chk_addr2 = 3'd0;
      fif.alu_valid = 1'b0; fif.alu_addr = 3'd0; fif.alu_data = 8'd0;
      fif.mem_valid = 1'b0; fif.mem_addr = 3'd0; fif.mem_data = 8'd0;
      fif.chk_addr1 = 3'd0; fif.chk_addr2 = 3'd0;

      //           r  av aa ad     mv ma md     c1 c2  we wa wd     gm ar mr h1 h2
      tbl[0]  = mk(0, 1, 3, 'h5A, 0, 0, 0,     0, 0,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0,    0, 0, 0,     3, 0,  1, 3, 'h5A,  0, 1, 1, 1, 0);
      tbl[2]  = mk(0, 0, 0, 0,    0, 0, 0,     3, 0,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[3]  = mk(0, 1, 1, 'h11, 1, 2, 'h22,  0, 0,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0,    0, 0, 0,     1, 2,  1, 2, 'h22,  1, 0, 1, 1, 1);
      tbl[5]  = mk(0, 0, 0, 0,    0, 0, 0,     1, 2,  1, 1, 'h11,  0, 1, 1, 1, 0);
      tbl[6]  = mk(0, 0, 0, 0,    0, 0, 0,     0, 0,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[7]  = mk(0, 1, 4, 'hAA, 1, 4, 'hBB,  0, 0,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[8]  = mk(0, 0, 0, 0,    0, 0, 0,     4, 0,  1, 4, 'hBB,  1, 0, 1, 1, 0);
      tbl[9]  = mk(0, 0, 0, 0,    0, 0, 0,     4, 0,  1, 4, 'hAA,  0, 1, 1, 1, 0);
      tbl[10] = mk(0, 0, 0, 0,    0, 0, 0,     0, 0,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[11] = mk(0, 0, 0, 0,    1, 7, 'h77,  0, 0,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[12] = mk(0, 1, 1, 'h01, 1, 6, 'h66,  0, 0,  1, 7, 'h77,  1, 1, 1, 0, 0);
      tbl[13] = mk(0, 0, 0, 0,    0, 0, 0,     6, 5,  1, 1, 'h01,  0, 1, 0, 1, 0);
      tbl[14] = mk(0, 0, 0, 0,    0, 0, 0,     6, 5,  1, 6, 'h66,  1, 1, 1, 1, 0);
      tbl[15] = mk(0, 0, 0, 0,    0, 0, 0,     6, 5,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[16] = mk(0, 1, 2, 'h12, 1, 3, 'h13,  2, 3,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[17] = mk(1, 0, 0, 0,    0, 0, 0,     2, 3,  1, 2, 'h12,  0, 1, 0, 1, 1);
      tbl[18] = mk(0, 0, 0, 0,    0, 0, 0,     2, 3,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[19] = mk(0, 0, 0, 0,    0, 0, 0,     3, 0,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[20] = mk(0, 1, 0, 'hA0, 1, 4, 'hB0,  0, 0,  0, 0, 0,     0, 1, 1, 0, 0);
      tbl[21] = mk(0, 1, 1, 'hA1, 1, 5, 'hB1,  0, 0,  1, 4, 'hB0,  1, 0, 1, 1, 1);
      tbl[22] = mk(0, 1, 1, 'hA1, 1, 6, 'hB2,  0, 0,  1, 0, 'hA0,  0, 1, 0, 1, 1);
      tbl[23] = mk(0, 1, 2, 'hA2, 1, 6, 'hB2,  0, 0,  1, 5, 'hB1,  1, 0, 1, 0, 0);
      tbl[24] = mk(0, 1, 2, 'hA2, 1, 7, 'hB3,  0, 0,  1, 1, 'hA1,  0, 1, 0, 0, 0);
      tbl[25] = mk(0, 1, 3, 'hA3, 1, 7, 'hB3,  0, 0,  1, 6, 'hB2,  1, 0, 1, 0, 0);
      tbl[26] = mk(0, 1, 3, 'hA3, 1, 4, 'hB4,  0, 0,  1, 2, 'hA2,  0, 1, 0, 0, 0);
      tbl[27] = mk(0, 1, 4, 'hA4, 1, 4, 'hB4,  0, 0,  1, 7, 'hB3,  1, 0, 1, 0, 0);
      tbl[28] = mk(0, 0, 0, 0,    0, 0, 0,     0, 0,  1, 3, 'hA3,  0, 1, 0, 0, 0);
      tbl[29] = mk(0, 0, 0, 0,    0, 0, 0,     0, 0,  1, 4, 'hB4,  1, 1, 1, 0, 0);
      tbl[30] = mk(0, 0, 0, 0,    0, 0, 0,     0, 0,  0, 0, 0,     0, 1, 1, 0, 0);

      ftbl[0]  = mk(0, 1, 4, 'hAA, 1, 2, 'h22, 4, 2,  0, 0, 0,     0, 1, 1, 0, 0);
      ftbl[1]  = mk(0, 0, 0, 0,    1, 4, 'hBB, 4, 2,  1, 2, 'h22,  1, 0, 1, 1, 1);
      ftbl[2]  = mk(0, 0, 0, 0,    0, 0, 0,    4, 2,  1, 4, 'hAA,  0, 1, 0, 1, 0);
      ftbl[3]  = mk(0, 1, 5, 'h55, 1, 6, 'h66, 4, 0,  1, 4, 'hBB,  1, 1, 1, 1, 0);
      ftbl[4]  = mk(0, 0, 0, 0,    0, 0, 0,    5, 6,  1, 6, 'h66,  1, 0, 1, 1, 1);
      ftbl[5]  = mk(0, 0, 0, 0,    0, 0, 0,    5, 6,  1, 5, 'h55,  0, 1, 1, 1, 0);
      ftbl[6]  = mk(0, 0, 0, 0,    0, 0, 0,    0, 0,  0, 0, 0,     0, 1, 1, 0, 0);
      ftbl[7]  = mk(0, 1, 4, 'hAA, 1, 4, 'hBB, 4, 0,  0, 0, 0,     0, 1, 1, 0, 0);
      ftbl[8]  = mk(0, 0, 0, 0,    0, 0, 0,    4, 0,  1, 4, 'hBB,  1, 0, 1, 1, 0);
      ftbl[9]  = mk(0, 0, 0, 0,    0, 0, 0,    4, 0,  1, 4, 'hAA,  0, 1, 1, 1, 0);
      ftbl[10] = mk(0, 0, 0, 0,    0, 0, 0,    0, 0,  0, 0, 0,     0, 1, 1, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      rst_f  = 1'b0;
      cap_en = 1'b1;

      for (int i = 0; i < 20; i++) run_row(1'b0, tbl[i], $sformatf("row%0d", i));
      check("rf3_kept", 17'(rf_dut[3]), 17'h5A);
      check("rf4_final", 17'(rf_dut[4]), 17'hAA);
      check("rf7", 17'(rf_dut[7]), 17'h77);
      for (int i = 20; i < 31; i++) run_row(1'b0, tbl[i], $sformatf("row%0d", i));

      for (int i = 0; i < 11; i++) run_row(1'b1, ftbl[i], $sformatf("fix%0d", i));
      check("fix_rf4_final", 17'(rf_fix[4]), 17'hAA);
      check("fix_rf6", 17'(rf_fix[6]), 17'h66);

      // Randomized traffic on the round-robin instance.
      for (int n = 0; n < 400; n++) begin
         rst           = ($urandom_range(63) == 0);
         mif.alu_valid = ($urandom_range(3) != 0);
         mif.alu_addr  = 3'($urandom_range(7));
         mif.alu_data  = 8'($urandom_range(255));
         mif.mem_valid = ($urandom_range(3) != 0);
         mif.mem_addr  = ($urandom_range(2) == 0) ? mif.alu_addr : 3'($urandom_range(7));
         mif.mem_data  = 8'($urandom_range(255));
         mif.chk_addr1 = 3'($urandom_range(7));
         mif.chk_addr2 = 3'($urandom_range(7));
         @(negedge clk);
         check($sformatf("rand%0d", n), outs_m(), m_expect());
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      mif.alu_valid = 1'b0;
      mif.mem_valid = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check($sformatf("drain%0d", n), outs_m(), m_expect());
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 8; i++)
         check($sformatf("rf_final%0d", i), 17'(rf_dut[i]), 17'(m_rf[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
